munoc_ahb_sram_slave_adapter: RTL and testbench
===============================================

Name: munoc_ahb_sram_slave_adapter

Overview:
- AHB-Lite slave that terminates the AHB master port of the MUNOC AHB slave network interface and drives a single-port synchronous SRAM (1-cycle read latency).
- Sits directly downstream of that interface. It consumes shsel/shaddr/shtrans/shwdata and returns shreadyout/shresp/shrdata.
- A one-entry write buffer decouples the AHB write data phase from the SRAM port. Illegal accesses get the standard two-cycle ERROR response.

Parameters:
- BW_PLATFORM_ADDR, 32, AHB address width.
- BW_NODE_DATA, 32, AHB/SRAM data width; legal values 32 or 64.
- BASE_ADDR, 0, byte address of SRAM word 0; must be aligned to the data width.
- MEM_DEPTH, 1024, SRAM depth in words.
- BW_MEM_ADDR, 10, SRAM word-address width; satisfies 2^BW_MEM_ADDR >= MEM_DEPTH.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rstnn  in  1  synchronous reset, active-high (1 = reset).
- shsel  in  1  slave select.
- shaddr  in  BW_PLATFORM_ADDR  byte address.
- shburst  in  3  burst type; ignored (every beat is an independent address phase).
- shmasterlock  in  1  ignored.
- shprot  in  4  ignored.
- shsize  in  3  transfer size, log2 bytes.
- shtrans  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
- shwrite  in  1  1 = write.
- shwdata  in  BW_NODE_DATA  write data, valid in the data phase.
- shready  in  1  bus ready; qualifies the address phase.
- shreadyout  out  1  slave ready.
- shresp  out  1  0=OKAY, 1=ERROR.
- shrdata  out  BW_NODE_DATA  read data.
- sram_cs  out  1  SRAM chip select.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  BW_MEM_ADDR  SRAM word address.
- sram_wben  out  BW_NODE_DATA/8  SRAM byte write enables.
- sram_wdata  out  BW_NODE_DATA  SRAM write data.
- sram_rdata  in  BW_NODE_DATA  SRAM read data, valid one cycle after sram_cs with sram_we=0.

Behaviour:
- Reset (synchronous, overrides everything, may hit mid-transfer):
  - shreadyout=1, shresp=0, shrdata=0.
  - sram_cs=0, sram_we=0, sram_addr=0, sram_wben=0, sram_wdata=0.
  - FSM returns to IDLE; the write buffer is invalidated and its content is dropped, not committed.
- Accept: shsel & shready & shtrans[1]. IDLE/BUSY or shsel=0 → no action; a data phase that follows gives OKAY with zero wait states.
- Legality check at accept. ERROR if any of:
  - shsize > log2(BW_NODE_DATA/8);
  - shaddr not aligned to shsize;
  - word index (shaddr-BASE_ADDR)>>log2(BW_NODE_DATA/8) >= MEM_DEPTH;
  - shaddr < BASE_ADDR.
- Byte lanes: mask of 2^shsize ones, shifted left by shaddr[log2(BW_NODE_DATA/8)-1:0].
- FSM states and transitions:
  - IDLE: on legal write accept → WDATA; on legal read accept → RD_ISSUE (or RD_WAITWB if the write buffer is valid); on illegal accept → ERR1.
  - WDATA: shreadyout=1, shresp=0. Load the write buffer with {word index, lane mask, shwdata & byte-lane-expanded mask}. The next accept is evaluated in this same cycle, as from IDLE.
  - Write buffer commit: the cycle after load, drive registered sram_cs=1, sram_we=1, sram_wben=mask, sram_wdata, sram_addr; buffer becomes invalid. A commit and a read issue never share a cycle.
  - RD_WAITWB: shreadyout=0 while the buffered write commits, then → RD_ISSUE. Read-after-write to the same word therefore returns the new data without forwarding.
  - RD_ISSUE: shreadyout=0; drive sram_cs=1, sram_we=0, sram_addr → RD_DATA.
  - RD_DATA: shrdata=sram_rdata, shreadyout=1, shresp=0. Accept is evaluated as in IDLE.
  - ERR1: shreadyout=0, shresp=1 → ERR2.
  - ERR2: shreadyout=1, shresp=1. Accept is evaluated as in IDLE. Illegal writes are never buffered; SRAM is untouched.
- Latency:
  - Write: 0 wait states; SRAM updated 2 cycles after the address phase.
  - Read: 1 wait state; 2 wait states when a buffered write is pending.
- shrdata holds its last value outside RD_DATA. sram_cs=0 whenever nothing is issued or committed.
- Back-to-back writes: a new write loads the buffer in the same cycle the previous entry commits (write-first ordering); no stall.

Test Plan:
- Reset then idle: hold rstnn=1 for 3 cycles mid-write (buffer valid) → all outputs at reset values, no sram_we pulse, shreadyout=1.
- Word write/read: write 0xDEADBEEF to BASE+0x10, then read BASE+0x10 → write 0 wait; sram_we at cycle +2 with addr=4, wben=0xF; read RD_WAITWB + RD_ISSUE stalls, shrdata=0xDEADBEEF.
- Byte write: shsize=0 to BASE+0x13 with data byte 0xA5 on lane 3 → sram_wben=0x8; a subsequent word read returns 0xA5ADBEEF.
- Errors: read at BASE+MEM_DEPTH*4, then halfword write at BASE+0x1 → each gives ERR1 (readyout=0, resp=1) then ERR2 (readyout=1, resp=1); sram_cs stays 0.
- Burst: INCR4 writes to 0x0/0x4/0x8/0xC with no gaps → 4 consecutive zero-wait data phases; commits at addr 0,1,2,3 on consecutive cycles.
- IDLE/BUSY: shtrans=1 with shsel=1, then shsel=0 with shtrans=2 → no SRAM activity, shreadyout stays 1, shresp=0.

Source files
------------

// File: rtl/munoc_ahb_sram_slave_adapter.sv
// AHB-Lite slave front end for a single-port synchronous SRAM with one-cycle read latency.
// Writes pass through a one-entry buffer; illegal accesses get the two-cycle ERROR response.
module munoc_ahb_sram_slave_adapter #(
   parameter int unsigned                  BW_PLATFORM_ADDR = 32,
   parameter int unsigned                  BW_NODE_DATA     = 32,
   parameter logic [BW_PLATFORM_ADDR-1:0]  BASE_ADDR        = '0,
   parameter int unsigned                  MEM_DEPTH        = 1024,
   parameter int unsigned                  BW_MEM_ADDR      = 10
) (
   input  logic                          clk,
   input  logic                          rstnn,
   input  logic                          shsel,
   input  logic [BW_PLATFORM_ADDR-1:0]   shaddr,
   input  logic [2:0]                    shburst,
   input  logic                          shmasterlock,
   input  logic [3:0]                    shprot,
   input  logic [2:0]                    shsize,
   input  logic [1:0]                    shtrans,
   input  logic                          shwrite,
   input  logic [BW_NODE_DATA-1:0]       shwdata,
   input  logic                          shready,
   output logic                          shreadyout,
   output logic                          shresp,
   output logic [BW_NODE_DATA-1:0]       shrdata,
   output logic                          sram_cs,
   output logic                          sram_we,
   output logic [BW_MEM_ADDR-1:0]        sram_addr,
   output logic [BW_NODE_DATA/8-1:0]     sram_wben,
   output logic [BW_NODE_DATA-1:0]       sram_wdata,
   input  logic [BW_NODE_DATA-1:0]       sram_rdata
);

   localparam int unsigned NB         = BW_NODE_DATA / 8;
   localparam int unsigned BYTE_SHIFT = $clog2(NB);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WDATA,
      ST_RD_WAITWB,
      ST_RD_ISSUE,
      ST_RD_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t                        state;
   state_t                        next_state;

   logic [BW_MEM_ADDR-1:0]        ph_index;
   logic [NB-1:0]                 ph_mask;
   logic [BW_NODE_DATA-1:0]       rdata_hold;

   logic [BW_PLATFORM_ADDR-1:0]   offset;
   logic [BW_PLATFORM_ADDR-1:0]   word_index;
   logic [BYTE_SHIFT-1:0]         lane_base;
   logic [NB-1:0]                 lane_mask;
   logic                          misaligned;
   logic                          access_ok;
   logic                          in_accept_state;
   logic                          accept;
   logic                          wb_load;
   logic [BW_MEM_ADDR-1:0]        read_index;
   logic [BW_NODE_DATA-1:0]       masked_wdata;
   logic                          ready_c;
   logic                          resp_c;

   logic                          unused_inputs;
   assign unused_inputs = ^{shburst, shmasterlock, shprot};

   // Address-phase decode: word index, byte lanes and the legality verdict.
   always_comb begin
      offset     = shaddr - BASE_ADDR;
      word_index = offset >> BYTE_SHIFT;
      lane_base  = shaddr[BYTE_SHIFT-1:0];
      misaligned = 1'b0;
      for (int i = 0; i < int'(BYTE_SHIFT); i++) begin
         if ((i < int'(shsize)) && lane_base[i]) begin
            misaligned = 1'b1;
         end
      end
      lane_mask = '0;
      for (int b = 0; b < int'(NB); b++) begin
         if ((b >= int'(lane_base)) && (b < int'(lane_base) + (1 << shsize))) begin
            lane_mask[b] = 1'b1;
         end
      end
      access_ok = (int'(shsize) <= int'(BYTE_SHIFT)) && !misaligned &&
                  (shaddr >= BASE_ADDR) &&
                  (word_index < BW_PLATFORM_ADDR'(MEM_DEPTH));
   end

   assign in_accept_state = (state == ST_IDLE) || (state == ST_WDATA) ||
                            (state == ST_RD_DATA) || (state == ST_ERR2);
   assign accept  = in_accept_state && shsel && shready && shtrans[1];
   assign wb_load = (state == ST_WDATA);

   // A read leaving RD_WAITWB uses the captured index; otherwise it issues straight from the bus.
   assign read_index = (state == ST_RD_WAITWB) ? ph_index : word_index[BW_MEM_ADDR-1:0];

   always_comb begin
      masked_wdata = '0;
      for (int b = 0; b < int'(NB); b++) begin
         if (ph_mask[b]) begin
            masked_wdata[8*b +: 8] = shwdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      next_state = state;
      ready_c    = 1'b1;
      resp_c     = 1'b0;
      case (state)
         ST_IDLE, ST_WDATA, ST_RD_DATA, ST_ERR2: begin
            resp_c     = (state == ST_ERR2);
            next_state = ST_IDLE;
            if (accept) begin
               if (!access_ok) begin
                  next_state = ST_ERR1;
               end else if (shwrite) begin
                  next_state = ST_WDATA;
               end else if (wb_load) begin
                  next_state = ST_RD_WAITWB;
               end else begin
                  next_state = ST_RD_ISSUE;
               end
            end
         end
         ST_RD_WAITWB: begin
            ready_c    = 1'b0;
            next_state = ST_RD_ISSUE;
         end
         ST_RD_ISSUE: begin
            ready_c    = 1'b0;
            next_state = ST_RD_DATA;
         end
         ST_ERR1: begin
            ready_c    = 1'b0;
            resp_c     = 1'b1;
            next_state = ST_ERR2;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   assign shreadyout = rstnn ? 1'b1 : ready_c;
   assign shresp     = rstnn ? 1'b0 : resp_c;
   assign shrdata    = rstnn ? '0 : ((state == ST_RD_DATA) ? sram_rdata : rdata_hold);

   always_ff @(posedge clk) begin
      if (rstnn) begin
         state      <= ST_IDLE;
         ph_index   <= '0;
         ph_mask    <= '0;
         rdata_hold <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            ph_index <= word_index[BW_MEM_ADDR-1:0];
            ph_mask  <= lane_mask;
         end
         if (state == ST_RD_DATA) begin
            rdata_hold <= sram_rdata;
         end
      end
   end

   // The SRAM port registers double as the write buffer: loading them is the commit of the
   // next cycle, and a read can only be issued in a cycle that carries no commit.
   always_ff @(posedge clk) begin
      if (rstnn) begin
         sram_cs    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wben  <= '0;
         sram_wdata <= '0;
      end else begin
         sram_cs <= 1'b0;
         sram_we <= 1'b0;
         if (wb_load) begin
            sram_cs    <= 1'b1;
            sram_we    <= 1'b1;
            sram_addr  <= ph_index;
            sram_wben  <= ph_mask;
            sram_wdata <= masked_wdata;
         end else if (next_state == ST_RD_ISSUE) begin
            sram_cs   <= 1'b1;
            sram_addr <= read_index;
            sram_wben <= '0;
         end
      end
   end

endmodule

// File: tb/tb_munoc_ahb_sram_slave_adapter.sv
// Directed bench for the AHB SRAM adapter with a behavioural SRAM and cycle-by-cycle checks.
module tb_munoc_ahb_sram_slave_adapter;

   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rstnn = 1'b1;
   logic        shsel;
   logic [31:0] shaddr;
   logic [2:0]  shburst;
   logic        shmasterlock;
   logic [3:0]  shprot;
   logic [2:0]  shsize;
   logic [1:0]  shtrans;
   logic        shwrite;
   logic [31:0] shwdata;
   logic        shready;
   logic        shreadyout;
   logic        shresp;
   logic [31:0] shrdata;
   logic        sram_cs;
   logic        sram_we;
   logic [9:0]  sram_addr;
   logic [3:0]  sram_wben;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   logic [31:0] mem [0:DEPTH-1];
   logic        mem_clear = 1'b1;

   int num_checks = 0;
   int num_errors = 0;

   always #5 clk = ~clk;

   assign shready = shreadyout;

   munoc_ahb_sram_slave_adapter #(
      .BW_PLATFORM_ADDR(32),
      .BW_NODE_DATA(32),
      .BASE_ADDR(BASE),
      .MEM_DEPTH(DEPTH),
      .BW_MEM_ADDR(10)
   ) dut (
      .clk(clk),
      .rstnn(rstnn),
      .shsel(shsel),
      .shaddr(shaddr),
      .shburst(shburst),
      .shmasterlock(shmasterlock),
      .shprot(shprot),
      .shsize(shsize),
      .shtrans(shtrans),
      .shwrite(shwrite),
      .shwdata(shwdata),
      .shready(shready),
      .shreadyout(shreadyout),
      .shresp(shresp),
      .shrdata(shrdata),
      .sram_cs(sram_cs),
      .sram_we(sram_we),
      .sram_addr(sram_addr),
      .sram_wben(sram_wben),
      .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   // Behavioural single-port SRAM with byte enables and one-cycle read latency.
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (sram_cs) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++) begin
               if (sram_wben[b]) begin
                  mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
               end
            end
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      num_checks++;
      assert (observed === expected) else begin
         num_errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic sel, input logic [1:0] trans, input logic write,
                                 input logic [2:0] size, input logic [31:0] addr);
      shsel   = sel;
      shtrans = trans;
      shwrite = write;
      shsize  = size;
      shaddr  = addr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bus(input string tag, input logic ready, input logic resp, input logic cs);
      check_output({tag, "_ready"}, 64'(shreadyout), 64'(ready));
      check_output({tag, "_resp"}, 64'(shresp), 64'(resp));
      check_output({tag, "_cs"}, 64'(sram_cs), 64'(cs));
   endtask

   task automatic check_commit(input string tag, input logic [9:0] addr, input logic [3:0] wben,
                               input logic [31:0] wdata);
      check_output({tag, "_cs"}, 64'(sram_cs), 64'd1);
      check_output({tag, "_we"}, 64'(sram_we), 64'd1);
      check_output({tag, "_addr"}, 64'(sram_addr), 64'(addr));
      check_output({tag, "_wben"}, 64'(sram_wben), 64'(wben));
      check_output({tag, "_wdata"}, 64'(sram_wdata), 64'(wdata));
   endtask

   task automatic check_issue(input string tag, input logic [9:0] addr);
      check_output({tag, "_ready"}, 64'(shreadyout), 64'd0);
      check_output({tag, "_cs"}, 64'(sram_cs), 64'd1);
      check_output({tag, "_we"}, 64'(sram_we), 64'd0);
      check_output({tag, "_addr"}, 64'(sram_addr), 64'(addr));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      shburst      = 3'd0;
      shmasterlock = 1'b0;
      shprot       = 4'd0;
      shwdata      = '0;
      apply_stimulus(1'b0, 2'd0, 1'b0, 3'd2, 32'h0);

      repeat (3) tick();
      check_output("rst_readyout", 64'(shreadyout), 64'd1);
      check_output("rst_resp", 64'(shresp), 64'd0);
      check_output("rst_rdata", 64'(shrdata), 64'd0);
      check_output("rst_cs", 64'(sram_cs), 64'd0);
      check_output("rst_we", 64'(sram_we), 64'd0);
      check_output("rst_addr", 64'(sram_addr), 64'd0);
      check_output("rst_wben", 64'(sram_wben), 64'd0);
      check_output("rst_wdata", 64'(sram_wdata), 64'd0);
      mem_clear = 1'b0;
      rstnn     = 1'b0;

      // Reset landing in a write data phase must drop the buffered word.
      apply_stimulus(1'b1, 2'd2, 1'b1, 3'd2, BASE + 32'h20);
      tick();
      shwdata = 32'h1111_1111;
      apply_stimulus(1'b0, 2'd0, 1'b0, 3'd2, 32'h0);
      rstnn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_output("midrst_we", 64'(sram_we), 64'd0);
         check_output("midrst_cs", 64'(sram_cs), 64'd0);
         check_output("midrst_ready", 64'(shreadyout), 64'd1);
      end
      rstnn = 1'b0;

      // Word write followed immediately by a read of the same word.
      apply_stimulus(1'b1, 2'd2, 1'b1, 3'd2, BASE + 32'h10);
      tick();
      check_bus("wr_dphase", 1'b1, 1'b0, 1'b0);
      shwdata = 32'hDEAD_BEEF;
      apply_stimulus(1'b1, 2'd2, 1'b0, 3'd2, BASE + 32'h10);
      tick();
      check_output("raw_waitwb_ready", 64'(shreadyout), 64'd0);
      check_commit("raw_commit", 10'd4, 4'hF, 32'hDEAD_BEEF);
      apply_stimulus(1'b0, 2'd0, 1'b0, 3'd2, 32'h0);
      tick();
      check_issue("raw_issue", 10'd4);
      tick();
      check_bus("raw_data", 1'b1, 1'b0, 1'b0);
      check_output("raw_rdata", 64'(shrdata), 64'hDEAD_BEEF);

      // Byte write on lane 3 with junk on the other lanes, then word read-back.
      apply_stimulus(1'b1, 2'd2, 1'b1, 3'd0, BASE + 32'h13);
      tick();
      check_output("byte_dphase_ready", 64'(shreadyout), 64'd1);
      shwdata = 32'hA5CC_CCCC;
      apply_stimulus(1'b1, 2'd2, 1'b0, 3'd2, BASE + 32'h10);
      tick();
      check_commit("byte_commit", 10'd4, 4'h8, 32'hA500_0000);
      apply_stimulus(1'b0, 2'd0, 1'b0, 3'd2, 32'h0);
      tick();
      check_issue("byte_issue", 10'd4);
      tick();
      check_output("byte_rdata", 64'(shrdata), 64'hA5AD_BEEF);

      // Out-of-range read.
      apply_stimulus(1'b1, 2'd2, 1'b0, 3'd2, BASE + DEPTH * 4);
      tick();
      check_bus("range_err1", 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 2'd0, 1'b0, 3'd2, 32'h0);
      tick();
      check_bus("range_err2", 1'b1, 1'b1, 1'b0);
      check_output("err_rdata_hold", 64'(shrdata), 64'hA5AD_BEEF);

      // Misaligned halfword write.
      apply_stimulus(1'b1, 2'd2, 1'b1, 3'd1, BASE + 32'h1);
      tick();
      check_bus("align_err1", 1'b0, 1'b1, 1'b0);
      shwdata = 32'hFFFF_FFFF;
      apply_stimulus(1'b0, 2'd0, 1'b0, 3'd2, 32'h0);
      tick();
      check_bus("align_err2", 1'b1, 1'b1, 1'b0);

      // Read below the base address.
      apply_stimulus(1'b1, 2'd2, 1'b0, 3'd2, BASE - 32'h4);
      tick();
      check_bus("below_err1", 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 2'd0, 1'b0, 3'd2, 32'h0);
      tick();
      check_bus("below_err2", 1'b1, 1'b1, 1'b0);

      // Transfer size wider than the bus.
      apply_stimulus(1'b1, 2'd2, 1'b0, 3'd3, BASE);
      tick();
      check_bus("size_err1", 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 2'd0, 1'b0, 3'd2, 32'h0);
      tick();
      check_bus("size_err2", 1'b1, 1'b1, 1'b0);
      tick();
      check_bus("post_err_idle", 1'b1, 1'b0, 1'b0);
      check_output("post_err_we", 64'(sram_we), 64'd0);

      // Gapless INCR4 write burst.
      apply_stimulus(1'b1, 2'd2, 1'b1, 3'd2, BASE);
      tick();
      check_output("burst_d0_ready", 64'(shreadyout), 64'd1);
      shwdata = 32'h0000_0100;
      apply_stimulus(1'b1, 2'd3, 1'b1, 3'd2, BASE + 32'h4);
      tick();
      check_output("burst_d1_ready", 64'(shreadyout), 64'd1);
      check_commit("burst_c0", 10'd0, 4'hF, 32'h0000_0100);
      shwdata = 32'h0000_0101;
      apply_stimulus(1'b1, 2'd3, 1'b1, 3'd2, BASE + 32'h8);
      tick();
      check_output("burst_d2_ready", 64'(shreadyout), 64'd1);
      check_commit("burst_c1", 10'd1, 4'hF, 32'h0000_0101);
      shwdata = 32'h0000_0102;
      apply_stimulus(1'b1, 2'd3, 1'b1, 3'd2, BASE + 32'hC);
      tick();
      check_output("burst_d3_ready", 64'(shreadyout), 64'd1);
      check_commit("burst_c2", 10'd2, 4'hF, 32'h0000_0102);
      shwdata = 32'h0000_0103;
      apply_stimulus(1'b0, 2'd0, 1'b0, 3'd2, 32'h0);
      tick();
      check_output("burst_end_ready", 64'(shreadyout), 64'd1);
      check_commit("burst_c3", 10'd3, 4'hF, 32'h0000_0103);
      tick();
      check_output("burst_quiet_cs", 64'(sram_cs), 64'd0);

      // BUSY with select, then NONSEQ without select: both ignored.
      apply_stimulus(1'b1, 2'd1, 1'b1, 3'd2, BASE + 32'h40);
      tick();
      check_bus("busy", 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 2'd2, 1'b1, 3'd2, BASE + 32'h40);
      tick();
      check_bus("nosel", 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 2'd0, 1'b0, 3'd2, 32'h0);
      tick();
      check_bus("nosel_after", 1'b1, 1'b0, 1'b0);
      check_output("nosel_we", 64'(sram_we), 64'd0);

      // Plain read with no pending write, then read of the word whose write was reset away.
      apply_stimulus(1'b1, 2'd2, 1'b0, 3'd2, BASE + 32'h8);
      tick();
      check_issue("rd2_issue", 10'd2);
      apply_stimulus(1'b0, 2'd0, 1'b0, 3'd2, 32'h0);
      tick();
      check_output("rd2_ready", 64'(shreadyout), 64'd1);
      check_output("rd2_rdata", 64'(shrdata), 64'h0000_0102);
      apply_stimulus(1'b1, 2'd2, 1'b0, 3'd2, BASE + 32'h20);
      tick();
      check_issue("rd8_issue", 10'd8);
      apply_stimulus(1'b0, 2'd0, 1'b0, 3'd2, 32'h0);
      tick();
      check_output("rd8_rdata_dropped", 64'(shrdata), 64'h0);
      tick();
      check_output("rd8_rdata_hold", 64'(shrdata), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
